// File: rtl/cvmcu_dbg_pkg.sv
// Shared types for the debug stop-timer responder: FSM state encoding and
// halt-counter width.
package cvmcu_dbg_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PEND    = 3'd1,
        HALTED  = 3'd2,
        RELEASE = 3'd3,
        TMO     = 3'd4
    } dbg_rsp_state_e;

    localparam int HALT_CNT_W = 16;

endpackage

// File: rtl/cvmcu_dbg_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module cvmcu_dbg_sat_cnt
    import cvmcu_dbg_pkg::*;
#(
    parameter int W = HALT_CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cvmcu_dbg_stoptimer_rsp.sv
// Core-side debug responder: freezes system timers while the core is (or is
// about to be) halted, with halt-timeout detection and a release hold-off.
module cvmcu_dbg_stoptimer_rsp
    import cvmcu_dbg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int RELEASE_DLY    = 4,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + RELEASE_DLY + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  debug_req_i,
    input  logic                  core_halted_i,
    input  logic                  stoptimer_en_i,
    output logic                  stoptimer_o,
    output logic                  halt_timeout_o,
    output logic [HALT_CNT_W-1:0] halt_count_o,
    output logic [2:0]            dbg_state_o
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    // RELEASE is never entered when RELEASE_DLY is 0, so the value is moot there.
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'((RELEASE_DLY == 0) ? 0 : RELEASE_DLY - 1);

    dbg_rsp_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stop_q, stop_d;
    logic             tmo_q, tmo_d;
    logic             halt_exit;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = 1'b0;
        halt_exit = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (core_halted_i) begin
                    state_d = HALTED;
                end else if (debug_req_i) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (core_halted_i) begin
                    state_d = HALTED;
                    cnt_d   = '0;
                end else if (!debug_req_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = TMO;
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TMO: begin
                // Held request stays parked here; no second timeout until IDLE.
                if (core_halted_i) begin
                    state_d = HALTED;
                end else if (!debug_req_i) begin
                    state_d = IDLE;
                end
            end
            HALTED: begin
                if (!core_halted_i) begin
                    halt_exit = 1'b1;
                    cnt_d     = '0;
                    state_d   = (RELEASE_DLY == 0) ? IDLE : RELEASE;
                end
            end
            RELEASE: begin
                if (core_halted_i) begin
                    state_d = HALTED;
                    cnt_d   = '0;
                end else if (cnt_q == REL_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output follows the next state so it rises together with dbg_state_o.
    assign stop_d = stoptimer_en_i &&
                    ((state_d == PEND) || (state_d == HALTED) || (state_d == RELEASE));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stop_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
            tmo_q   <= tmo_d;
        end
    end

    cvmcu_dbg_sat_cnt #(
        .W (HALT_CNT_W)
    ) u_halt_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (1'b0),
        .inc_i  (halt_exit),
        .cnt_o  (halt_count_o)
    );

    assign stoptimer_o    = stop_q;
    assign halt_timeout_o = tmo_q;
    assign dbg_state_o    = state_q;

endmodule
